// File: rtl/multi_pulse_controller.sv
// multi_pulse_controller
// Multi-channel debounced pulse generator for single-stepping a pipelined core.
// Each channel synchronises a raw button, debounces the press and the release,
// then emits a fixed-width clock pulse plus a one-cycle strobe per accepted
// press. While the button is held, optional auto-repeat re-fires after a gap.
// Channels are completely independent; they share only clock and reset.

module multi_pulse_controller #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 28,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 100000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [NUM_CH-1:0] sw_input,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] clk_pulse,
  output logic [NUM_CH-1:0] fire_strobe,
  output logic [NUM_CH-1:0] busy
);

  // Counter reload values. Every countdown runs from X-1 to 0 inclusive, so a
  // phase lasts exactly X cycles before the cnt==0 decision is taken.
  localparam logic [CNT_W-1:0] DEB_LOAD    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

  // IDLE    : waiting for a press
  // ARM     : press seen, counting stable-high samples
  // FIRE    : clock pulse being driven high
  // HOLD    : pulse done, button still held (repeat gap or parked at 0)
  // REL     : release seen, counting stable-low samples
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    HOLD = 3'd3,
    REL  = 3'd4
  } state_t;

  // First flop may go metastable; only the second-flop output s_in is used.
  logic [NUM_CH-1:0] sync_meta;
  logic [NUM_CH-1:0] s_in;

  // Two-flop synchroniser for every raw button input.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_meta <= '0;
      s_in      <= '0;
    end else begin
      sync_meta <= sw_input;
      s_in      <= sync_meta;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             strobe_q;
    logic             strobe_d;

    // State, counter and registered outputs; reset truncates any pulse at once.
    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        strobe_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
        strobe_q <= strobe_d;
      end
    end

    // Next-state and counter update; every decision uses the synchronised level.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (s_in[ch]) begin
            state_d = ARM;
            cnt_d   = DEB_LOAD;
          end
        end
        ARM: begin
          if (!s_in[ch]) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = FIRE;
            cnt_d   = PULSE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        FIRE: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = HOLD;
            cnt_d   = REPEAT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HOLD: begin
          if (!s_in[ch]) begin
            state_d = REL;
            cnt_d   = DEB_LOAD;
          end else if (cnt_q == CNT_ZERO) begin
            if (repeat_en[ch]) begin
              state_d = FIRE;
              cnt_d   = PULSE_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        REL: begin
          if (s_in[ch]) begin
            state_d = HOLD;
            cnt_d   = REPEAT_LOAD;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode from the next state so the pulse and strobe are registered.
    always_comb begin
      pulse_d  = (state_d == FIRE);
      strobe_d = (state_d == FIRE) && (state_q != FIRE);
    end

    assign clk_pulse[ch]   = pulse_q;
    assign fire_strobe[ch] = strobe_q;
    assign busy[ch]        = (state_q != IDLE);

  end

endmodule

// File: tb/tb_multi_pulse_controller.sv
// tb_multi_pulse_controller
// Directed bench with small counter values. Inputs are driven between edges;
// outputs are sampled 1 ns after each rising edge. "Edge 0" is the first
// rising edge that samples the new raw button level.

module tb_multi_pulse_controller;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              clear_n;
  logic [NUM_CH-1:0] sw_input;
  logic [NUM_CH-1:0] repeat_en;
  logic [NUM_CH-1:0] clk_pulse;
  logic [NUM_CH-1:0] fire_strobe;
  logic [NUM_CH-1:0] busy;

  int checks = 0;
  int errors = 0;

  multi_pulse_controller #(
    .NUM_CH(NUM_CH),
    .CNT_W(28),
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(3),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk(clk),
    .clear_n(clear_n),
    .sw_input(sw_input),
    .repeat_en(repeat_en),
    .clk_pulse(clk_pulse),
    .fire_strobe(fire_strobe),
    .busy(busy)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Quiet reset with all buttons released, then one idle edge after release.
  task automatic apply_reset();
    clear_n   = 1'b0;
    sw_input  = '0;
    repeat_en = '0;
    repeat (3) @(posedge clk);
    #1;
    clear_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_n   = 1'b0;
    sw_input  = '1;
    repeat_en = '1;
    #3;
    checks++;
    if (clk_pulse !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_pulse got %b want 0000", clk_pulse);
    end
    checks++;
    if (fire_strobe !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_strobe got %b want 0000", fire_strobe);
    end
    checks++;
    if (busy !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_busy got %b want 0000", busy);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({clk_pulse, fire_strobe, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_held got %b want 000000000000", {clk_pulse, fire_strobe, busy});
    end
  endtask

  task automatic test_single_press();
    logic [3:0] exp_p, exp_s, exp_b;
    apply_reset();
    sw_input = 4'b0001;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      exp_p = (e >= 6 && e <= 8) ? 4'b0001 : 4'b0000;
      exp_s = (e == 6) ? 4'b0001 : 4'b0000;
      exp_b = (e >= 2) ? 4'b0001 : 4'b0000;
      checks++;
      if (clk_pulse !== exp_p) begin
        errors++;
        $display("[TB] FAIL single_pulse edge %0d got %b want %b", e, clk_pulse, exp_p);
      end
      checks++;
      if (fire_strobe !== exp_s) begin
        errors++;
        $display("[TB] FAIL single_strobe edge %0d got %b want %b", e, fire_strobe, exp_s);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("[TB] FAIL single_busy edge %0d got %b want %b", e, busy, exp_b);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_b;
    apply_reset();
    for (int e = 0; e < 16; e++) begin
      sw_input = (e < 3) ? 4'b0010 : 4'b0000;
      @(posedge clk);
      #1;
      exp_b = (e >= 2 && e <= 4) ? 4'b0010 : 4'b0000;
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("[TB] FAIL glitch_busy edge %0d got %b want %b", e, busy, exp_b);
      end
      checks++;
      if (clk_pulse !== 4'b0000 || fire_strobe !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL glitch_fire edge %0d got pulse %b strobe %b want 0000 0000",
                 e, clk_pulse, fire_strobe);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_p, exp_s;
    apply_reset();
    repeat_en = 4'b0100;
    sw_input  = 4'b0100;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      #1;
      exp_p = (e >= 6 && ((e - 6) % 13) < 3) ? 4'b0100 : 4'b0000;
      exp_s = (e >= 6 && ((e - 6) % 13) == 0) ? 4'b0100 : 4'b0000;
      checks++;
      if (clk_pulse !== exp_p) begin
        errors++;
        $display("[TB] FAIL repeat_pulse edge %0d got %b want %b", e, clk_pulse, exp_p);
      end
      checks++;
      if (fire_strobe !== exp_s) begin
        errors++;
        $display("[TB] FAIL repeat_strobe edge %0d got %b want %b", e, fire_strobe, exp_s);
      end
    end
  endtask

  // Raw ch3: high edges 0..14, low 15..16, high 17, low afterwards.
  // FSM sees raw(e-2) at edge e: REL@17, HOLD@19, REL@20, IDLE@24.
  task automatic test_release_bounce();
    logic [3:0] exp_p, exp_b;
    apply_reset();
    for (int e = 0; e < 32; e++) begin
      sw_input = (e < 15 || e == 17) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      exp_p = (e >= 6 && e <= 8) ? 4'b1000 : 4'b0000;
      exp_b = (e >= 2 && e <= 23) ? 4'b1000 : 4'b0000;
      checks++;
      if (clk_pulse !== exp_p) begin
        errors++;
        $display("[TB] FAIL bounce_pulse edge %0d got %b want %b", e, clk_pulse, exp_p);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("[TB] FAIL bounce_busy edge %0d got %b want %b", e, busy, exp_b);
      end
    end
  endtask

  // Counter parks at 0 in HOLD; raising repeat_en before edge 25 fires at 25.
  task automatic test_late_repeat();
    logic [3:0] exp_p, exp_s;
    apply_reset();
    sw_input = 4'b0001;
    for (int e = 0; e < 45; e++) begin
      repeat_en = (e >= 25) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      exp_p = ((e >= 6 && e <= 8) || (e >= 25 && ((e - 25) % 13) < 3)) ? 4'b0001 : 4'b0000;
      exp_s = (e == 6 || e == 25 || e == 38) ? 4'b0001 : 4'b0000;
      checks++;
      if (clk_pulse !== exp_p) begin
        errors++;
        $display("[TB] FAIL late_pulse edge %0d got %b want %b", e, clk_pulse, exp_p);
      end
      checks++;
      if (fire_strobe !== exp_s) begin
        errors++;
        $display("[TB] FAIL late_strobe edge %0d got %b want %b", e, fire_strobe, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] exp_p, exp_s, exp_b;
    apply_reset();
    sw_input = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({clk_pulse[0], fire_strobe[0], busy[0]} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL midreset_before got %b want 111", {clk_pulse[0], fire_strobe[0], busy[0]});
    end
    #2;
    clear_n = 1'b0;
    #1;
    checks++;
    if ({clk_pulse, fire_strobe, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_async got %b want 000000000000", {clk_pulse, fire_strobe, busy});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({clk_pulse, fire_strobe, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_held got %b want 000000000000", {clk_pulse, fire_strobe, busy});
    end
    clear_n = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      exp_p = (e >= 6 && e <= 8) ? 4'b0001 : 4'b0000;
      exp_s = (e == 6) ? 4'b0001 : 4'b0000;
      exp_b = (e >= 2) ? 4'b0001 : 4'b0000;
      checks++;
      if ({clk_pulse, fire_strobe, busy} !== {exp_p, exp_s, exp_b}) begin
        errors++;
        $display("[TB] FAIL midreset_refire edge %0d got %b %b %b want %b %b %b",
                 e, clk_pulse, fire_strobe, busy, exp_p, exp_s, exp_b);
      end
    end
  endtask

  task automatic test_all_channels();
    logic [3:0] exp_p, exp_s, exp_b;
    apply_reset();
    repeat_en = 4'b0101;
    sw_input  = 4'b1111;
    for (int e = 0; e < 31; e++) begin
      @(posedge clk);
      #1;
      exp_p = ((e >= 6 && e <= 8) ? 4'b1111 : 4'b0000) |
              ((e >= 19 && e <= 21) ? 4'b0101 : 4'b0000);
      exp_s = (e == 6) ? 4'b1111 : ((e == 19) ? 4'b0101 : 4'b0000);
      exp_b = (e >= 2) ? 4'b1111 : 4'b0000;
      checks++;
      if (clk_pulse !== exp_p) begin
        errors++;
        $display("[TB] FAIL all_pulse edge %0d got %b want %b", e, clk_pulse, exp_p);
      end
      checks++;
      if (fire_strobe !== exp_s) begin
        errors++;
        $display("[TB] FAIL all_strobe edge %0d got %b want %b", e, fire_strobe, exp_s);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("[TB] FAIL all_busy edge %0d got %b want %b", e, busy, exp_b);
      end
    end
  endtask

  initial begin
    clear_n   = 1'b0;
    sw_input  = '0;
    repeat_en = '0;
    $display("[TB] start");
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_release_bounce();
    test_late_repeat();
    test_reset_mid_pulse();
    test_all_channels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pulse_controller.md
Name: multi_pulse_controller

Overview:
- Parametrised, multi-channel successor to the single-switch pulse generator used for FPGA single-stepping of the pipelined MIPS core.
- Each channel synchronises a raw pushbutton/switch and debounces both press and release.
- Each channel emits a fixed-width clock pulse plus a one-cycle strobe per accepted press.
- Optional per-channel auto-repeat re-fires while the button is held, for multi-cycle stepping without repeated presses.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 28, width of each per-channel down-counter
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a press or release (>=1, < 2**CNT_W)
PULSE_CYCLES, 100000000, clk_pulse high time per fire, in clk cycles (>=1, < 2**CNT_W)
REPEAT_CYCLES, 50000000, low gap between auto-repeat pulses while held (>=1, < 2**CNT_W)

Ports:
clk  in  1  system clock, all logic on rising edge
clear_n  in  1  asynchronous active-low reset
sw_input  in  NUM_CH  raw asynchronous button/switch levels, bit i = channel i
repeat_en  in  NUM_CH  per-channel auto-repeat enable, sampled each cycle, no synchroniser
clk_pulse  out  NUM_CH  registered pulse, high PULSE_CYCLES cycles per fire
fire_strobe  out  NUM_CH  registered one-cycle strobe on the first clk_pulse cycle of each fire
busy  out  NUM_CH  high whenever the channel FSM is not IDLE

Behaviour:
- Reset: clear_n low forces all of the following to 0, asynchronously: synchroniser flops, FSM (IDLE), counters, clk_pulse, fire_strobe, busy. Reset asserted mid-pulse truncates the pulse immediately. No fire occurs after release until a fresh press passes debounce.
- Synchroniser: 2-flop per channel. s_in is the second-flop output. All FSM decisions use s_in only.
- Per-channel FSM (5 states, channels fully independent, cnt is CNT_W bits). "Load X-1" means cnt <= X-1.
  - IDLE: clk_pulse=0. If s_in=1: go ARM, load DEBOUNCE_CYCLES-1.
  - ARM: If s_in=0: go IDLE (glitch rejected). Else if cnt==0: go FIRE, load PULSE_CYCLES-1. Else cnt--.
  - FIRE: clk_pulse=1. s_in ignored. If cnt==0: go HOLD, load REPEAT_CYCLES-1. Else cnt--.
  - HOLD: clk_pulse=0.
    - s_in=0: go REL, load DEBOUNCE_CYCLES-1.
    - s_in=1, cnt==0, repeat_en=1: go FIRE, load PULSE_CYCLES-1.
    - s_in=1, cnt==0, repeat_en=0: stay, cnt holds at 0 (no wrap).
    - Otherwise: cnt--.
  - REL: clk_pulse=0. If s_in=1: go HOLD, load REPEAT_CYCLES-1 (bounce on release). Else if cnt==0: go IDLE. Else cnt--.
- clk_pulse: registered output, equals (next state == FIRE). No combinational path from any input to any output.
- fire_strobe: 1 for exactly the first cycle of each FIRE entry.
- Timing: raw input high and stable, first sampled at edge 0.
  - s_in is 1 from edge 1.
  - ARM is entered at edge 2.
  - clk_pulse rises at edge DEBOUNCE_CYCLES+2 and stays high for exactly PULSE_CYCLES cycles.
  - Auto-repeat period is PULSE_CYCLES+REPEAT_CYCLES cycles.
- Press accepted during FIRE: the pulse always completes full width. Releasing during FIRE is resolved in HOLD.
- repeat_en toggled while in HOLD: takes effect at the next cnt==0 evaluation. A counter already at 0 with repeat_en rising fires on the next cycle.
- busy: 1 in ARM, FIRE, HOLD and REL.

Test Plan:
Use DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, REPEAT_CYCLES=10, NUM_CH=4 for all scenarios.
1. Reset then ch0 raw high from edge 0, repeat_en=0, held 40 cycles -> clk_pulse[0] high at edges 6..8 only, fire_strobe[0] high at edge 6 only, no further pulses; other channels stay 0.
2. ch1 raw high 3 cycles then low -> never fires; busy[1] rises then returns to 0; clk_pulse[1] stays 0.
3. ch2 held with repeat_en[2]=1 for 50 cycles -> pulses begin at edges 6, 19, 32, 45, each 3 cycles wide, with one strobe per pulse.
4. ch3 release bounce: after fire, raw low 2 cycles, high 1, low 10 -> FSM goes REL->HOLD->REL->IDLE with no extra pulse; busy[3] falls 4+2 cycles after final synced low.
5. clear_n pulsed low during clk_pulse[0]=1 -> clk_pulse, fire_strobe and busy go 0 asynchronously; raw held high afterwards -> new pulse 6 edges after clear_n release.
6. All four channels pressed on the same edge with repeat_en=4'b0101 -> identical first-pulse timing on all channels; only ch0 and ch2 repeat.
